// File: rtl/game_soc_usb_pkg.sv
// Shared definitions for the USB host-controller reset sequencer:
// FSM state encoding, Avalon register addresses and a small helper.
package game_soc_usb_pkg;

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } usb_rst_state_e;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_COUNT    = 2'd1;
  localparam logic [7:0] DONE_CNT_MAX = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_soc_usb_rst_timer.sv
// Loadable, clearable up-counter with a terminal compare.
// tc_o is high whenever the count has reached or passed term_i, so the
// caller can saturate by gating inc_i with tc_o.
module game_soc_usb_rst_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q >= term_i);

endmodule

// File: rtl/game_soc_usb_rst_seq.sv
// Reset sequencer for the external USB host controller (MAX3421E RES_N).
// Stretches the software reset request to a minimum pulse, waits a settle
// interval after release, runs one sequence automatically after power-on,
// and reports status plus a completed-reset count on an Avalon-MM slave.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_ASSERT | usb_res_n low; held until min width met and rst_req low
// ST_SETTLE | usb_res_n high; waiting for the chip to settle
// ST_READY  | chip out of reset and settled; waits for a rst_req rise
module game_soc_usb_rst_seq
  import game_soc_usb_pkg::*;
#(
  parameter int ASSERT_CYCLES = 50,
  parameter int SETTLE_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_res_n,
  output logic        usb_ready
);

  localparam int TW = $clog2(max2(ASSERT_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [TW-1:0] ASSERT_TERM = TW'(ASSERT_CYCLES);
  localparam logic [TW-1:0] SETTLE_TERM = TW'(SETTLE_CYCLES - 1);

  usb_rst_state_e state_q, state_d;
  logic           rst_req_q;
  logic           usb_res_n_q, usb_res_n_d;
  logic           usb_ready_q, usb_ready_d;
  logic [7:0]     done_cnt_q, done_cnt_d;

  logic           rise;
  logic           tmr_clr, tmr_inc, tmr_tc;
  logic [TW-1:0]  tmr_term;
  logic           cnt_inc, cnt_clr;
  logic           unused_wdata;

  assign rise         = rst_req & ~rst_req_q;
  assign cnt_clr      = chipselect & ~write_n & (address == REG_COUNT);
  assign unused_wdata = ^writedata;
  assign tmr_term     = (state_q == ST_SETTLE) ? SETTLE_TERM : ASSERT_TERM;

  game_soc_usb_rst_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ({TW{1'b0}}),
    .inc_i      (tmr_inc),
    .term_i     (tmr_term),
    .tc_o       (tmr_tc)
  );

  // State, request history and registered outputs; reset lands in ASSERT
  // so releasing reset_n starts the power-on sequence by itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      rst_req_q   <= 1'b0;
      usb_res_n_q <= 1'b0;
      usb_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_req_q   <= rst_req;
      usb_res_n_q <= usb_res_n_d;
      usb_ready_q <= usb_ready_d;
    end
  end

  // Next-state decode plus timer and completion-count strobes.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (tmr_tc && !rst_req) begin
          state_d = ST_SETTLE;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = ~tmr_tc;
        end
      end
      ST_SETTLE: begin
        if (rise) begin
          state_d = ST_ASSERT;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = ST_READY;
          tmr_clr = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_READY: begin
        if (rise) begin
          state_d = ST_ASSERT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Outputs decoded from the next state so they switch with the state register.
  always_comb begin
    usb_res_n_d = (state_d != ST_ASSERT);
    usb_ready_d = (state_d == ST_READY);
  end

  // Completed-reset counter; a software clear beats a same-cycle increment.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (cnt_clr) begin
      done_cnt_d = 8'h00;
    end else if (cnt_inc && (done_cnt_q != DONE_CNT_MAX)) begin
      done_cnt_d = done_cnt_q + 8'h01;
    end
  end

  // Completed-reset counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt_q <= 8'h00;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = 32'h0;
    case (address)
      REG_STATUS: readdata = {28'b0, state_q, (state_q != ST_READY), usb_ready_q};
      REG_COUNT:  readdata = {24'b0, done_cnt_q};
      default:    readdata = 32'h0;
    endcase
  end

  assign usb_res_n = usb_res_n_q;
  assign usb_ready = usb_ready_q;

endmodule

// File: tb/tb_game_soc_usb_rst_seq.sv
// Bench for the USB reset sequencer with ASSERT_CYCLES=4, SETTLE_CYCLES=10.
module tb_game_soc_usb_rst_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rst_req;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        usb_res_n;
  logic        usb_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        req;
    logic        cs;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        exp_res_n;
    logic        exp_ready;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  game_soc_usb_rst_seq #(
    .ASSERT_CYCLES (4),
    .SETTLE_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rst_req    (rst_req),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .usb_res_n  (usb_res_n),
    .usb_ready  (usb_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic cs, input logic wr_n, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic res_n, input logic rdy,
                     input logic [31:0] rd);
    vec_t v;
    v.req = req; v.cs = cs; v.wr_n = wr_n; v.addr = addr; v.wdata = wdata;
    v.exp_res_n = res_n; v.exp_ready = rdy; v.exp_rd = rd;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!usb_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Drives rst_req high for high_cycles edges, then counts sampled low cycles of usb_res_n.
  task automatic measure_low(input int high_cycles, output int low);
    low = 0;
    rst_req = 1'b1;
    for (int i = 0; i < high_cycles; i++) begin
      tick();
      if (!usb_res_n) low++;
    end
    rst_req = 1'b0;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (!usb_res_n) low++;
      else break;
    end
  endtask

  task automatic do_pulse();
    int n;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    wait_ready(n);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    int low, settle;
    logic [31:0] rd;

    // Power-on: edges 1..4 in ASSERT, SETTLE from edge 5, READY at edge 15.
    for (int i = 0; i < 4; i++) add(0, 0, 1, 2'd0, 32'h0, 0, 0, 32'h6);
    add(0, 0, 1, 2'd0, 32'h0, 1, 0, 32'hA);
    for (int i = 0; i < 9; i++) add(0, 0, 1, 2'd1, 32'h0, 1, 0, 32'h0);
    add(0, 0, 1, 2'd0, 32'h0, 1, 1, 32'h1);
    add(0, 0, 1, 2'd1, 32'h0, 1, 1, 32'h1);
    // One-cycle software pulse: low on the rise edge plus 4 counting edges.
    add(1, 0, 1, 2'd0, 32'h0, 0, 0, 32'h6);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 2'd0, 32'h0, 0, 0, 32'h6);
    add(0, 0, 1, 2'd0, 32'h0, 1, 0, 32'hA);
    for (int i = 0; i < 9; i++) add(0, 0, 1, 2'd1, 32'h0, 1, 0, 32'h1);
    add(0, 0, 1, 2'd1, 32'h0, 1, 1, 32'h2);
    // Writes to non-count addresses are ignored; unused addresses read 0.
    add(0, 1, 0, 2'd0, 32'hFFFF_FFFF, 1, 1, 32'h1);
    add(0, 1, 0, 2'd2, 32'hFFFF_FFFF, 1, 1, 32'h0);
    add(0, 0, 1, 2'd3, 32'h0, 1, 1, 32'h0);
    add(0, 0, 1, 2'd1, 32'h0, 1, 1, 32'h2);

    reset_n = 1'b0; rst_req = 1'b0; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    repeat (3) tick();
    chk("rst_res_n", {31'b0, usb_res_n}, 32'h0);
    chk("rst_ready", {31'b0, usb_ready}, 32'h0);
    read_reg(2'd0, rd); chk("rst_reg0", rd, 32'h6);
    read_reg(2'd1, rd); chk("rst_reg1", rd, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      rst_req = vecs[i].req; chipselect = vecs[i].cs; write_n = vecs[i].wr_n;
      address = vecs[i].addr; writedata = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_res_n", i), {31'b0, usb_res_n}, {31'b0, vecs[i].exp_res_n});
      chk($sformatf("vec%0d_ready", i), {31'b0, usb_ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end
    chipselect = 1'b0; write_n = 1'b1; rst_req = 1'b0;

    // Held request: 20 high samples keep usb_res_n low for 20 cycles.
    measure_low(20, low);
    chk("held_low", low, 20);
    read_reg(2'd0, rd); chk("held_settle_reg0", rd, 32'hA);
    wait_ready(settle);
    chk("held_settle", settle, 10);
    read_reg(2'd1, rd); chk("held_count", rd, 32'h3);

    // Abort during SETTLE: rise 5 edges after SETTLE entry.
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    repeat (9) tick();
    read_reg(2'd0, rd); chk("abort_pre_reg0", rd, 32'hA);
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    read_reg(2'd0, rd); chk("abort_reg0", rd, 32'h6);
    chk("abort_res_n", {31'b0, usb_res_n}, 32'h0);
    read_reg(2'd1, rd); chk("abort_count_hold", rd, 32'h3);
    low = 1;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (!usb_res_n) low++;
      else break;
    end
    chk("abort_low", low, 5);
    wait_ready(settle);
    chk("abort_settle", settle, 10);
    read_reg(2'd1, rd); chk("abort_count", rd, 32'h4);

    // Saturation at 0xFF.
    for (int i = 0; i < 251; i++) do_pulse();
    read_reg(2'd1, rd); chk("sat_255", rd, 32'hFF);
    do_pulse();
    read_reg(2'd1, rd); chk("sat_hold", rd, 32'hFF);

    // Clear by write to address 1.
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h1234_5678;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    read_reg(2'd1, rd); chk("clr_count", rd, 32'h0);

    // Clear coincident with completion: READY reached 15 edges after the rise edge.
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    repeat (14) tick();
    chk("coinc_pre_ready", {31'b0, usb_ready}, 32'h0);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    chk("coinc_ready", {31'b0, usb_ready}, 32'h1);
    read_reg(2'd1, rd); chk("coinc_count", rd, 32'h0);
    do_pulse();
    read_reg(2'd1, rd); chk("post_clr_count", rd, 32'h1);

    // Async reset in the middle of SETTLE.
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    repeat (7) tick();
    read_reg(2'd0, rd); chk("mid_settle_reg0", rd, 32'hA);
    #1 reset_n = 1'b0;
    #1;
    chk("async_res_n", {31'b0, usb_res_n}, 32'h0);
    chk("async_ready", {31'b0, usb_ready}, 32'h0);
    read_reg(2'd1, rd); chk("async_count", rd, 32'h0);
    read_reg(2'd0, rd); chk("async_reg0", rd, 32'h6);
    tick(); tick();
    reset_n = 1'b1;
    low = 0;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (!usb_res_n) low++;
      else break;
    end
    chk("restart_low", low, 4);
    wait_ready(settle);
    chk("restart_settle", settle, 10);
    read_reg(2'd1, rd); chk("restart_count", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
